// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between the decode/issue stage, its upstream
// instruction source and the downstream ALU.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_op;
  logic        illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_in1, alu_in2, alu_op, illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_in1, alu_in2, alu_op, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes an instruction into registered ALU operands/op.
// Optional one-entry skid buffer enabled by defining ALU_ISSUE_SKID_EN.
module alu_issue_stage #(
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  op;
    logic        ill;
  } entry_t;

  function automatic logic [3:0] map_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  map_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  map_op = 4'b0010;
      3'b010:  map_op = 4'b0011;
      3'b011:  map_op = 4'b0100;
      3'b100:  map_op = 4'b0101;
      3'b101:  map_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  map_op = 4'b1000;
      default: map_op = 4'b1001;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic [31:0] imm_i, imm_s, imm_u;
  entry_t      dec;

  assign opcode   = bus.instr[6:0];
  assign f3       = bus.instr[14:12];
  assign f7       = bus.instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i    = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s    = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u    = {bus.instr[31:12], 12'b0};

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = is_shift ? {27'b0, bus.rs2_data[4:0]} : bus.rs2_data;
        dec.op  = map_op(f3, bus.instr[30]);
        dec.ill = !((f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = is_shift ? {27'b0, bus.instr[24:20]} : imm_i;
        // Only srai/srli use instr[30]; addi never becomes sub.
        dec.op  = map_op(f3, (f3 == 3'b101) && bus.instr[30]);
        dec.ill = (f3 == 3'b001 && f7 != 7'b0000000) ||
                  (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
      end
      OPC_LUI:   dec.in2 = imm_u;
      OPC_AUIPC: begin
        dec.in1 = bus.pc;
        dec.in2 = imm_u;
      end
      OPC_LOAD: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = imm_i;
      end
      OPC_STORE: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = imm_s;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.in1 = '0;
      dec.in2 = '0;
      dec.op  = ILLEGAL_OP;
    end
  end

  entry_t out_q;
  logic   out_valid_q;
  logic   ready;
  logic   take_in;

  assign take_in       = bus.in_valid && ready && !bus.flush;
  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_in1   = out_q.in1;
  assign bus.alu_in2   = out_q.in2;
  assign bus.alu_op    = out_q.op;
  assign bus.illegal   = out_q.ill;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_full;

  assign ready = !skid_full || bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      skid_full   <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      // Skid is full only while in_ready is low, so it never races a new accept.
      if (skid_full) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_full   <= 1'b0;
      end else if (take_in) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (take_in) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end
  end
`else
  assign ready = bus.flush || !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (take_in) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

endmodule
